// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile -- architectural register file for the 5-stage pipelined processor.
//
// 32 x WIDTH-bit registers. Register 0 is hardwired to zero and has no storage.
// One synchronous write port, driven by the W stage. Two combinational read
// ports, driven by the D stage.
//
// Optional feature, selected by the macro REGFILE_BYPASS_EN:
//   When the macro is defined, a write and a read of the same nonzero index in
//   the same cycle return the new write data on that read port (write-first).
//   When it is undefined, such a read returns the stored value from before the
//   edge, and the processor forwards W-stage results itself.
//
// Ports:
//   clock             in   master clock; state updates on the rising edge
//   reset             in   asynchronous, active-high; clears every register
//   ctrl_writeEnable  in   write strobe
//   ctrl_writeReg     in   [4:0] destination index (a write to index 0 is dropped)
//   data_writeReg     in   [WIDTH-1:0] write data
//   ctrl_readRegA     in   [4:0] port A source index
//   ctrl_readRegB     in   [4:0] port B source index
//   data_readRegA     out  [WIDTH-1:0] port A read data
//   data_readRegB     out  [WIDTH-1:0] port B read data
// -----------------------------------------------------------------------------
module regfile #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_writeEnable,
    input  logic [4:0]       ctrl_writeReg,
    input  logic [WIDTH-1:0] data_writeReg,
    input  logic [4:0]       ctrl_readRegA,
    input  logic [4:0]       ctrl_readRegB,
    output logic [WIDTH-1:0] data_readRegA,
    output logic [WIDTH-1:0] data_readRegB
);

    // The index width is fixed at 5 bits, so the register count cannot vary.
    if (NUM_REGS != 32) begin : g_bad_num_regs
        $error("regfile: NUM_REGS must be 32 (5-bit register index)");
    end

    // Physical storage for r1..r31. There is no r0 entry.
    logic [WIDTH-1:0]    regs [1:NUM_REGS-1];

    // Write decode, one-hot. Bit 0 is absent, so a write to r0 cannot select anything.
    logic [NUM_REGS-1:1] wr_onehot;

    // Stored values selected by each read port, before any bypass.
    logic [WIDTH-1:0]    stored_a;
    logic [WIDTH-1:0]    stored_b;

    // -------------------------------------------------------------------------
    // Write decoder: 5-to-32 one-hot, gated by the write enable.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default every always_comb output before the conditional logic,
        // so no path leaves the signal unassigned and no latch is inferred.
        wr_onehot = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ctrl_writeEnable && (ctrl_writeReg == 5'(i))) begin
                wr_onehot[i] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage. An asynchronous reset clears every register at once.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: this storage is clearly reset, unlike a RAM macro. The
            // architecture requires every register to read 0 while reset is
            // high, so the array must be built from flops, not inferred RAM.
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_onehot[i]) begin
                    // NOTE: use non-blocking assignments for clocked state, so
                    // every register samples pre-edge values and the result
                    // does not depend on process ordering.
                    regs[i] <= data_writeReg;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read muxes: two independent 32:1 selections. Index 0, and any index
    // without a match, falls through to zero, so no read returns X.
    // -------------------------------------------------------------------------
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ctrl_readRegA == 5'(i)) stored_a = regs[i];
            if (ctrl_readRegB == 5'(i)) stored_b = regs[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Write-first bypass, per port. Index 0 never bypasses. Bypass is held off
    // during reset so that the outputs follow the cleared storage.
    logic bypass_a;
    logic bypass_b;

    assign bypass_a = ctrl_writeEnable && (ctrl_writeReg != 5'd0) &&
                      (ctrl_writeReg == ctrl_readRegA) && !reset;
    assign bypass_b = ctrl_writeEnable && (ctrl_writeReg != 5'd0) &&
                      (ctrl_writeReg == ctrl_readRegB) && !reset;

    assign data_readRegA = bypass_a ? data_writeReg : stored_a;
    assign data_readRegB = bypass_b ? data_writeReg : stored_b;
`else
    // No bypass: reads see the stored value from before the edge.
    assign data_readRegA = stored_a;
    assign data_readRegB = stored_b;
`endif

endmodule
